// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the 6502: derives the one-cycle CPU clock-enable
// and the CPU reset from the board clock, with periodic automatic restart.
module cpu_run_ctrl #(
  parameter int unsigned DIV           = 6000000,
  parameter int unsigned RES_CYCLES    = 2,
  parameter int unsigned RESTART_TICKS = 15,
  parameter int unsigned DEB_CYCLES    = 120000
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       run,
  input  logic       step,
  input  logic       halt_req,
  output logic       cpu_ce,
  output logic       cpu_res,
  output logic [7:0] tick_cnt,
  output logic [1:0] state
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(RES_CYCLES + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST   = PW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_DONE    = HW'(RES_CYCLES);
  localparam logic [DW-1:0] DEB_LAST     = DW'(DEB_CYCLES - 1);
  localparam logic [7:0]    RESTART_LAST = 8'(RESTART_TICKS - 1);
  localparam bit            RESTART_EN   = (RESTART_TICKS != 0);

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_HALT  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0]    tick_cnt_q, tick_cnt_d;
  logic          cpu_ce_q, cpu_ce_d;
  logic          cpu_res_q, cpu_res_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          step_edge_q, step_edge_d;
  logic          tick;
  logic          count_pulse;

  assign tick = (presc_q == PRESC_LAST);

  // Prescaler free-runs in every state so halts and mode changes never skew the grid.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Step button: two-flop synchroniser, then a stability counter.
  always_comb begin
    sync1_d     = step;
    sync2_d     = sync1_q;
    level_d     = level_q;
    deb_cnt_d   = deb_cnt_q;
    step_edge_d = 1'b0;
    if (sync2_q == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      level_d     = ~level_q;
      deb_cnt_d   = '0;
      step_edge_d = ~level_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    tick_cnt_d  = tick_cnt_q;
    cpu_ce_d    = 1'b0;
    count_pulse = 1'b0;
    case (state_q)
      S_RESET: begin
        tick_cnt_d = '0;
        if (hold_q == HOLD_DONE) begin
          state_d = run ? S_RUN : S_STEP;
        end else if (tick) begin
          cpu_ce_d = 1'b1;
          hold_d   = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        if (halt_req)  state_d = S_HALT;
        else if (!run) state_d = S_STEP;
        else if (tick) count_pulse = 1'b1;
      end
      S_STEP: begin
        if (halt_req)         state_d = S_HALT;
        else if (run)         state_d = S_RUN;
        else if (step_edge_q) count_pulse = 1'b1;
      end
      S_HALT: begin
        if (!halt_req) state_d = run ? S_RUN : S_STEP;
      end
      default: state_d = S_RESET;
    endcase

    // The restart pulse still issues; the CPU sees it together with reset.
    if (count_pulse) begin
      cpu_ce_d = 1'b1;
      if (RESTART_EN && (tick_cnt_q == RESTART_LAST)) begin
        state_d    = S_RESET;
        tick_cnt_d = '0;
        hold_d     = '0;
      end else begin
        tick_cnt_d = tick_cnt_q + 8'd1;
      end
    end

    cpu_res_d = (state_d == S_RESET);
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q     <= S_RESET;
      presc_q     <= '0;
      hold_q      <= '0;
      tick_cnt_q  <= '0;
      cpu_ce_q    <= 1'b0;
      cpu_res_q   <= 1'b1;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      deb_cnt_q   <= '0;
      step_edge_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      hold_q      <= hold_d;
      tick_cnt_q  <= tick_cnt_d;
      cpu_ce_q    <= cpu_ce_d;
      cpu_res_q   <= cpu_res_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      deb_cnt_q   <= deb_cnt_d;
      step_edge_q <= step_edge_d;
    end
  end

  assign cpu_ce   = cpu_ce_q;
  assign cpu_res  = cpu_res_q;
  assign tick_cnt = tick_cnt_q;
  assign state    = state_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Sequencer for the 6502 core on the board: generates the CPU clock-enable and CPU reset from the 12 MHz board clock.
- Supports free-run at a divided rate, single-step from a push button, halt on request, and automatic periodic restart.
- Sits between the board clock/buttons and the `cpu` instance (drives its enable and `R` inputs).

Parameters:
- DIV, 6000000: cpu_ce period in CLK cycles in RUN; legal range ≥2.
- RES_CYCLES, 2: number of cpu_ce pulses issued while cpu_res is held high; legal range ≥1.
- RESTART_TICKS, 15: RUN-mode cpu_ce count after which the CPU is re-reset; 0 disables restart. Max 255.
- DEB_CYCLES, 120000: consecutive stable CLK cycles required to accept a new step-button level (10 ms at 12 MHz).

Ports:
- CLK  in  1  board clock (12 MHz).
- R  in  1  synchronous active-high reset.
- run  in  1  mode switch: 1 = free-run, 0 = single-step. Treated as a quasi-static level; not debounced.
- step  in  1  raw step button, asynchronous, active-high.
- halt_req  in  1  synchronous halt request, level.
- cpu_ce  out  1  one-CLK-cycle CPU clock-enable pulse.
- cpu_res  out  1  CPU reset, active-high.
- tick_cnt  out  8  cpu_ce pulses since last restart, wrapping at 255→0.
- state  out  2  FSM state: 00 RESET_HOLD, 01 RUN, 10 STEP_WAIT, 11 HALTED.

Behaviour:
- All outputs registered. On R=1 at a CLK edge:
  - cpu_ce=0, cpu_res=1, tick_cnt=0, state=RESET_HOLD.
  - Prescaler=0, hold counter=0, debouncer level=0, debounce counter=0.
- R has priority over every other event, including mid-step and mid-hold.
- Prescaler:
  - Counts 0..DIV-1 every cycle in all states; wraps to 0.
  - tick is internal and combinational: prescaler==DIV-1.
  - Any cpu_ce caused by tick goes high in the cycle after tick, so the RUN-mode cpu_ce period is exactly DIV cycles.
  - First tick-driven pulse after R release: DIV cycles after the first non-reset edge.
- Step debouncer:
  - 2-flop synchroniser, then counter. Counter resets whenever the synchronised input equals the debounced level.
  - When it reaches DEB_CYCLES-1 with the input differing, the debounced level flips.
  - step_edge is a single cycle on the debounced 0→1 transition.
- RESET_HOLD:
  - cpu_res=1; cpu_ce follows tick, because the 6502 needs clocks during reset.
  - A hold counter counts the issued pulses. When the RES_CYCLES-th pulse issues, the next cycle has cpu_res=0 and the state goes to RUN if run=1, else STEP_WAIT.
  - tick_cnt is held at 0.
  - halt_req is ignored in this state.
- RUN:
  - cpu_ce follows tick; tick_cnt increments on each cpu_ce.
  - Restart: if RESTART_TICKS≠0 and a pulse is issued with tick_cnt==RESTART_TICKS-1, the next state is RESET_HOLD. That pulse still issues, tick_cnt clears to 0 and the hold counter clears.
  - If halt_req=1: next state HALTED and the tick in that same cycle is suppressed (no cpu_ce).
  - Priority: halt_req over restart.
  - Else if run=0: next state STEP_WAIT; a coincident tick is suppressed.
- STEP_WAIT:
  - Tick is ignored.
  - step_edge produces cpu_ce=1 in the next cycle and tick_cnt++. Restart rules apply as in RUN.
  - halt_req=1 → HALTED; a coincident step_edge is dropped.
  - run=1 → RUN; a coincident step_edge is dropped.
- HALTED:
  - cpu_ce=0; tick and step are ignored; tick_cnt holds.
  - When halt_req=0: go to RUN if run=1, else STEP_WAIT.
  - The prescaler keeps its phase throughout, so no pulse-timing skew is introduced beyond dropped pulses.
- cpu_ce is never high in two consecutive cycles. Pulses are only ever dropped, never delayed.
- Target size: 150–250 lines of RTL.

Test Plan (DIV=4, RES_CYCLES=2, RESTART_TICKS=5, DEB_CYCLES=3):
- Power-up:
  - Stimulus: R high 3 cycles, run=1, halt_req=0.
  - Response: cpu_res=1 with cpu_ce pulses at cycles 4 and 8 after release; cpu_res=0 and state=01 from cycle 9; cpu_ce every 4 cycles thereafter.
- Periodic restart:
  - Stimulus: continue the power-up run.
  - Response: after 5 RUN pulses, tick_cnt shows 4 then 0, state=00, cpu_res=1 for 2 more pulses, then RUN again; cycle repeats indefinitely.
- Single-step with bounce:
  - Stimulus: run=0; step toggles 1,0,1 on single cycles, then holds 1 for 10 cycles.
  - Response: exactly one cpu_ce, 2 sync + 3 debounce + 1 cycles after the stable rise; tick_cnt +1; no cpu_ce from the prescaler.
- Halt collision:
  - Stimulus: assert halt_req in the same cycle prescaler==3.
  - Response: no cpu_ce in the next cycle; state=11; tick_cnt frozen for 20 cycles.
  - Stimulus: release halt_req.
  - Response: state=01 and next cpu_ce aligned to the original 4-cycle grid.
- Mode switch:
  - Stimulus: drop run coincident with tick.
  - Response: pulse suppressed; state=10.
  - Stimulus: raise run.
  - Response: state=01 next cycle.
- Reset mid-operation:
  - Stimulus: R pulse in STEP_WAIT while a debounced step is pending, and separately in HALTED.
  - Response: all outputs return to reset values the next cycle; the pending step is lost.
